// File: rtl/cov_seq_ctrl.sv
// cov_seq_ctrl: address and strobe sequencer for the four-pass covariance engine
// (column sum, mean divide, centering, pairwise MAC). Optional macro: COV_SYM_EN.
module cov_seq_ctrl #(
   parameter int N      = 100,
   parameter int AW     = 14,
   parameter int RD_LAT = 2,
   localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stall,
   output logic          busy,
   output logic          done,
   output logic [2:0]    phase,
   output logic          mem_en,
   output logic [AW-1:0] addr_a,
   output logic [AW-1:0] addr_b,
   output logic [CW-1:0] col_idx,
   output logic          mean_acc_en,
   output logic          div_en,
   output logic          ctr_we,
   output logic [AW-1:0] ctr_waddr,
   output logic          mac_clr,
   output logic          mac_en,
   output logic          res_we,
   output logic [AW-1:0] res_addr
`ifdef COV_SYM_EN
   ,
   output logic          res_mirror_we,
   output logic [AW-1:0] res_mirror_addr
`endif
);

   localparam logic [AW-1:0] LAST_A   = AW'(N * N - 1);
   localparam logic [AW-1:0] NSTEP    = AW'(N);
   localparam logic [CW-1:0] NM1      = CW'(N - 1);
   localparam logic [2:0]    DR_LAST  = 3'(RD_LAT);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MEAN = 3'd1,
      S_DIV  = 3'd2,
      S_CTR  = 3'd3,
      S_COV  = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   // One issue slot travelling RD_LAT cycles alongside the BRAM read.
   typedef struct packed {
      logic          mean;
      logic          ctr;
      logic          mac;
      logic          clr;
      logic          last;
`ifdef COV_SYM_EN
      logic          mir;
      logic [AW-1:0] maddr;
`endif
      logic [CW-1:0] col;
      logic [AW-1:0] addr;
   } slot_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_drain;
   logic [2:0]    r_dcnt;
   logic [CW-1:0] r_col;
   logic [CW-1:0] r_div;
   logic [CW-1:0] r_i;
   logic [CW-1:0] r_j;
   logic [CW-1:0] r_k;
   logic [AW-1:0] r_addr_a;
   logic [AW-1:0] r_addr_b;
   logic [AW-1:0] r_row;
`ifdef COV_SYM_EN
   logic [AW-1:0] r_jrow;
   logic          r_mir_v;
   logic [AW-1:0] r_mir_addr;
`endif
   logic          r_res_v;
   logic [AW-1:0] r_res_addr;
   slot_t         r_pipe [RD_LAT];
   slot_t         w_slot;
   slot_t         w_out;
   logic          w_act;
   logic          w_issue;
   logic          w_last_issue;
   logic          w_drain_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_act        = (r_state == S_MEAN) || (r_state == S_CTR) || (r_state == S_COV);
      w_issue      = w_act && !r_drain;
      w_drain_end  = w_act && r_drain && (r_dcnt == DR_LAST) && !stall;
      w_last_issue = 1'b0;
      w_state_nxt  = r_state;
      if (r_state == S_COV) w_last_issue = (r_k == NM1) && (r_j == NM1) && (r_i == NM1);
      else                  w_last_issue = (r_addr_a == LAST_A);
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_MEAN;
         S_MEAN:  if (w_drain_end) w_state_nxt = S_DIV;
         S_DIV:   if (!stall && (r_div == NM1)) w_state_nxt = S_CTR;
         S_CTR:   if (w_drain_end) w_state_nxt = S_COV;
         S_COV:   if (w_drain_end) w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_slot = '0;
      if (w_issue) begin
         case (r_state)
            S_MEAN: begin
               w_slot.mean = 1'b1;
               w_slot.col  = r_col;
            end
            S_CTR: begin
               w_slot.ctr  = 1'b1;
               w_slot.col  = r_col;
               w_slot.addr = r_addr_a;
            end
            S_COV: begin
               w_slot.mac  = 1'b1;
               w_slot.clr  = (r_k == '0);
               w_slot.last = (r_k == NM1);
               w_slot.addr = r_row + AW'(r_j);
`ifdef COV_SYM_EN
               w_slot.mir   = (r_i != r_j);
               w_slot.maddr = r_jrow + AW'(r_i);
`endif
            end
            default: w_slot = '0;
         endcase
      end
   end

   // Counters and address accumulators; everything holds while stall is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_drain  <= 1'b0;
         r_dcnt   <= '0;
         r_col    <= '0;
         r_div    <= '0;
         r_i      <= '0;
         r_j      <= '0;
         r_k      <= '0;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_row    <= '0;
`ifdef COV_SYM_EN
         r_jrow   <= '0;
`endif
      end else if (r_state == S_IDLE) begin
         if (start) begin
            r_drain  <= 1'b0;
            r_dcnt   <= '0;
            r_col    <= '0;
            r_div    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_row    <= '0;
`ifdef COV_SYM_EN
            r_jrow   <= '0;
`endif
         end
      end else if (!stall) begin
         if (r_drain) begin
            if (r_dcnt == DR_LAST) begin
               r_drain <= 1'b0;
               r_dcnt  <= '0;
               if (r_state == S_CTR) begin
                  r_i      <= '0;
                  r_j      <= '0;
                  r_k      <= '0;
                  r_addr_a <= '0;
                  r_addr_b <= '0;
                  r_row    <= '0;
`ifdef COV_SYM_EN
                  r_jrow   <= '0;
`endif
               end
            end else begin
               r_dcnt <= r_dcnt + 3'd1;
            end
         end else begin
            case (r_state)
               S_MEAN, S_CTR: begin
                  if (w_last_issue) begin
                     r_drain <= 1'b1;
                  end else begin
                     r_addr_a <= r_addr_a + AW'(1);
                     r_col    <= (r_col == NM1) ? '0 : r_col + CW'(1);
                  end
               end
               S_DIV: begin
                  if (r_div == NM1) begin
                     r_div    <= '0;
                     r_addr_a <= '0;
                     r_col    <= '0;
                  end else begin
                     r_div <= r_div + CW'(1);
                  end
               end
               S_COV: begin
                  if (r_k != NM1) begin
                     r_k      <= r_k + CW'(1);
                     r_addr_a <= r_addr_a + NSTEP;
                     r_addr_b <= r_addr_b + NSTEP;
                  end else begin
                     r_k <= '0;
                     if (r_j != NM1) begin
                        r_j      <= r_j + CW'(1);
                        r_addr_a <= AW'(r_i);
                        r_addr_b <= AW'(r_j) + AW'(1);
`ifdef COV_SYM_EN
                        r_jrow   <= r_jrow + NSTEP;
`endif
                     end else if (r_i != NM1) begin
                        r_i      <= r_i + CW'(1);
                        r_row    <= r_row + NSTEP;
                        r_addr_a <= AW'(r_i) + AW'(1);
`ifdef COV_SYM_EN
                        // Upper triangle: the next row starts on its diagonal.
                        r_j      <= r_i + CW'(1);
                        r_addr_b <= AW'(r_i) + AW'(1);
                        r_jrow   <= r_row + NSTEP;
`else
                        r_j      <= '0;
                        r_addr_b <= '0;
`endif
                     end else begin
                        r_drain <= 1'b1;
                     end
                  end
               end
               default: r_drain <= r_drain;
            endcase
         end
      end
   end

   // Alignment pipe: slot enters with the issue, exits when the data returns.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < RD_LAT; n++) r_pipe[n] <= '0;
      end else if (!stall) begin
         r_pipe[0] <= w_slot;
         for (int n = 1; n < RD_LAT; n++) r_pipe[n] <= r_pipe[n-1];
      end
   end

   assign w_out = r_pipe[RD_LAT-1];

   // Result-write stage: one cycle behind the final product of a pair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_res_v    <= 1'b0;
         r_res_addr <= '0;
`ifdef COV_SYM_EN
         r_mir_v    <= 1'b0;
         r_mir_addr <= '0;
`endif
      end else if (!stall) begin
         r_res_v <= w_out.mac && w_out.last;
         if (w_out.mac && w_out.last) r_res_addr <= w_out.addr;
`ifdef COV_SYM_EN
         r_mir_v <= w_out.mac && w_out.last && w_out.mir;
         if (w_out.mac && w_out.last) r_mir_addr <= w_out.maddr;
`endif
      end
   end

   assign busy        = w_act || (r_state == S_DIV);
   assign done        = (r_state == S_FIN);
   assign phase       = r_state;
   assign mem_en      = w_issue && !stall;
   assign addr_a      = r_addr_a;
   assign addr_b      = r_addr_b;
   assign col_idx     = (r_state == S_DIV) ? r_div : w_out.col;
   assign mean_acc_en = w_out.mean && !stall;
   assign div_en      = (r_state == S_DIV) && !stall;
   assign ctr_we      = w_out.ctr && !stall;
   assign ctr_waddr   = w_out.ctr ? w_out.addr : '0;
   assign mac_clr     = w_out.mac && w_out.clr && !stall;
   assign mac_en      = w_out.mac && !w_out.clr && !stall;
   assign res_we      = r_res_v && !stall;
   assign res_addr    = r_res_addr;
`ifdef COV_SYM_EN
   assign res_mirror_we   = r_mir_v && !stall;
   assign res_mirror_addr = r_mir_addr;
`endif

endmodule

// File: tb/tb_cov_seq_ctrl.sv
// Directed bench for cov_seq_ctrl at N=4, RD_LAT=2; follows COV_SYM_EN when defined.
module tb_cov_seq_ctrl;

   localparam int N      = 4;
   localparam int AW     = 8;
   localparam int RD_LAT = 2;
   localparam int CW     = 2;
`ifdef COV_SYM_EN
   localparam int NPAIR  = 10;
   localparam int T_DONE = 86;
   localparam int PAIR12 = 5;
   int exp_res [NPAIR] = '{0, 1, 2, 3, 5, 6, 7, 10, 11, 15};
   int exp_mir [6]     = '{4, 8, 12, 9, 13, 14};
`else
   localparam int NPAIR  = 16;
   localparam int T_DONE = 110;
   localparam int PAIR12 = 6;
   int exp_res [NPAIR] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

   logic          clk = 1'b0;
   logic          reset, start, stall;
   logic          busy, done, mem_en, mean_acc_en, div_en, ctr_we, mac_clr, mac_en, res_we;
   logic [2:0]    phase;
   logic [AW-1:0] addr_a, addr_b, ctr_waddr, res_addr;
   logic [CW-1:0] col_idx;
`ifdef COV_SYM_EN
   logic          res_mirror_we;
   logic [AW-1:0] res_mirror_addr;
`endif

   cov_seq_ctrl #(.N(N), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .busy(busy), .done(done), .phase(phase), .mem_en(mem_en),
      .addr_a(addr_a), .addr_b(addr_b), .col_idx(col_idx),
      .mean_acc_en(mean_acc_en), .div_en(div_en), .ctr_we(ctr_we),
      .ctr_waddr(ctr_waddr), .mac_clr(mac_clr), .mac_en(mac_en),
      .res_we(res_we), .res_addr(res_addr)
`ifdef COV_SYM_EN
      , .res_mirror_we(res_mirror_we), .res_mirror_addr(res_mirror_addr)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int busy_cnt, done_cnt, done_rel, first_mem, first_mean, viol, multi, post_busy;
   int ph [5];
   int q_mean[$], q_ctr[$], q_res[$], q_clr[$], q_cova[$], q_covb[$], q_mir[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_pass(input int stall_at, input int stall_len, input int restart_at,
                           input int abort_at);
      int quiet;
      int s;
      busy_cnt = 0; done_cnt = 0; done_rel = 0; first_mem = 0; first_mean = 0;
      viol = 0; multi = 0; post_busy = 0;
      for (int p = 0; p < 5; p++) ph[p] = -1;
      q_mean.delete(); q_ctr.delete(); q_res.delete(); q_clr.delete();
      q_cova.delete(); q_covb.delete(); q_mir.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int rel = 1; rel <= 400; rel++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_rel == 0) begin
               done_rel = rel;
               ph[4] = int'(phase);
            end
         end
         if (mem_en && first_mem == 0) first_mem = rel;
         if (mean_acc_en) begin
            if (first_mean == 0) first_mean = rel;
            q_mean.push_back(int'(col_idx));
         end
         if (ctr_we) q_ctr.push_back(int'(ctr_waddr));
         if (mac_en || mac_clr) q_clr.push_back(int'(mac_clr));
         if (res_we) q_res.push_back(int'(res_addr));
         if (mem_en && phase == 3'd4) begin
            q_cova.push_back(int'(addr_a));
            q_covb.push_back(int'(addr_b));
         end
`ifdef COV_SYM_EN
         if (res_mirror_we) q_mir.push_back(int'(res_mirror_addr));
         if (res_mirror_we && !res_we) multi++;
`endif
         if (stall && (mem_en || mean_acc_en || div_en || ctr_we || mac_en || mac_clr || res_we))
            viol++;
         s = int'(mean_acc_en) + int'(div_en) + int'(ctr_we);
         if ((s > 1) || (s != 0 && (mac_en || mac_clr || res_we)) || (mac_en && mac_clr)) multi++;
         if (rel == 1)  ph[0] = int'(phase);
         if (rel == 20) ph[1] = int'(phase);
         if (rel == 24) ph[2] = int'(phase);
         if (rel == 43) ph[3] = int'(phase);
         if (rel == abort_at) begin
            #2 reset = 1'b0;
            #1;
            chk("abort_ctl", int'({busy, done, phase, mem_en}), 0);
            chk("abort_strb", int'({mean_acc_en, div_en, ctr_we, mac_en, mac_clr, res_we}), 0);
            chk("abort_addr", int'({addr_a, addr_b, res_addr, ctr_waddr}), 0);
            @(negedge clk);
            reset = 1'b1;
            quiet = 0;
            repeat (4) begin
               @(negedge clk);
               quiet = quiet | int'({busy, done, mem_en, mean_acc_en, div_en, ctr_we,
                                     mac_en, mac_clr, res_we});
            end
            chk("abort_quiet", quiet, 0);
            return;
         end
         start = (rel + 1 == restart_at);
         stall = (rel + 1 >= stall_at) && (rel + 1 < stall_at + stall_len);
         if (done_rel != 0) break;
      end
      start = 1'b0;
      stall = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (busy || done) post_busy++;
      end
   endtask

   task automatic check_common(input int exp_done);
      int bad;
      chk("done_latency", done_rel, exp_done);
      chk("done_pulses", done_cnt, 1);
      chk("busy_cycles", busy_cnt, exp_done - 1);
      chk("post_idle", post_busy, 0);
      chk("mean_count", q_mean.size(), N * N);
      bad = 0;
      foreach (q_mean[n]) if (q_mean[n] != n % N) bad++;
      chk("mean_cols", bad, 0);
      chk("ctr_count", q_ctr.size(), N * N);
      bad = 0;
      foreach (q_ctr[n]) if (q_ctr[n] != n) bad++;
      chk("ctr_addrs", bad, 0);
      chk("res_count", q_res.size(), NPAIR);
      bad = 0;
      foreach (q_res[n]) if (n < NPAIR && q_res[n] != exp_res[n]) bad++;
      chk("res_addrs", bad, 0);
      chk("mac_count", q_clr.size(), N * NPAIR);
      bad = 0;
      foreach (q_clr[n]) if (q_clr[n] != ((n % N == 0) ? 1 : 0)) bad++;
      chk("mac_clr_first", bad, 0);
      bad = 0;
      for (int k = 0; k < N; k++) begin
         if (q_cova.size() <= PAIR12 * N + k) bad++;
         else if (q_cova[PAIR12*N+k] != k * N + 1 || q_covb[PAIR12*N+k] != k * N + 2) bad++;
      end
      chk("pair12_reads", bad, 0);
      chk("stall_quiet", viol, 0);
      chk("strobe_exclusive", multi, 0);
`ifdef COV_SYM_EN
      chk("mirror_count", q_mir.size(), 6);
      bad = 0;
      foreach (q_mir[n]) if (n < 6 && q_mir[n] != exp_mir[n]) bad++;
      chk("mirror_addrs", bad, 0);
`endif
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_ctl", int'({busy, done, phase, mem_en}), 0);
      chk("reset_strb", int'({mean_acc_en, div_en, ctr_we, mac_en, mac_clr, res_we}), 0);
      chk("reset_addr", int'({addr_a, addr_b, res_addr, ctr_waddr}), 0);
      chk("reset_col", int'(col_idx), 0);
      reset = 1'b1;
      stall = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_stall", int'({busy, phase, mem_en, div_en}), 0);
      stall = 1'b0;

      // Clean run with a stray start while busy.
      run_pass(0, 0, 50, 0);
      check_common(T_DONE);
      chk("mean_latency", first_mean - first_mem, RD_LAT);
      chk("phase_mean", ph[0], 1);
      chk("phase_div", ph[1], 2);
      chk("phase_center", ph[2], 3);
      chk("phase_cov", ph[3], 4);
      chk("phase_fin", ph[4], 5);

      // Five stalled cycles inside CENTER.
      run_pass(30, 5, 0, 0);
      check_common(T_DONE + 5);

      // Reset pulse during COV, then a fresh run.
      run_pass(0, 0, 0, 60);
      run_pass(0, 0, 0, 0);
      check_common(T_DONE);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
